// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, 16x oversampling.
// Holds the last good byte with sticky frame and overrun flags.
module uart_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       pClk,
    input  logic       pReset,
    input  logic       RxD,
    input  logic       rd_ack,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_done,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          rx_meta;
    logic          rx_s;

    logic [CW-1:0] div_cnt;
    logic          run;
    logic          tick;

    logic [3:0]    tick_idx;
    logic [3:0]    tick_idx_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;

    logic          accept;
    logic          stop_err;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rx_s    <= rx_meta;
        end
    end

    // Oversample divider only runs while a frame is being timed.
    assign run  = (state != IDLE) && (state != WAIT_HIGH);
    assign tick = run && (div_cnt == DIV_LAST);

    // Oversample tick counter, wraps after DIV cycles.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            div_cnt <= '0;
        end else if (!run) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // Frame state and datapath registers.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            state    <= IDLE;
            tick_idx <= 4'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
        end else begin
            state    <= state_next;
            tick_idx <= tick_idx_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
        end
    end

    // Next-state logic: centre on the start bit, then sample every 16 ticks.
    always_comb begin
        state_next    = state;
        tick_idx_next = tick_idx;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        accept        = 1'b0;
        stop_err      = 1'b0;
        unique case (state)
            IDLE: begin
                tick_idx_next = 4'd0;
                bit_idx_next  = 3'd0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_idx == 4'd7) begin
                        tick_idx_next = 4'd0;
                        bit_idx_next  = 3'd0;
                        state_next    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_idx_next = tick_idx + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tick_idx_next = tick_idx + 4'd1;
                    if (tick_idx == 4'd15) begin
                        shift_next   = {rx_s, shift[7:1]};
                        bit_idx_next = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state_next = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tick_idx_next = tick_idx + 4'd1;
                    if (tick_idx == 4'd15) begin
                        if (rx_s) begin
                            accept     = 1'b1;
                            state_next = IDLE;
                        end else begin
                            stop_err   = 1'b1;
                            state_next = WAIT_HIGH;
                        end
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Holding register: a simultaneous read does not count as an overrun.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else if (accept) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
        end else if (rd_ack) begin
            rx_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new error event beats a clear in the same cycle.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (stop_err) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (accept && rx_valid && !rd_ack) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign rx_done = accept;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a byte scoreboard.
// Runs at DIV = 4 so one bit lasts 64 clocks.
module tb_uart_rx;

    localparam int CLK_FREQ = 6400000;
    localparam int BAUD     = 100000;
    localparam int BITC     = 64;

    logic       pClk = 1'b0;
    logic       pReset = 1'b1;
    logic       RxD = 1'b1;
    logic       rd_ack = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_done;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int fall_cyc = 0;
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD)
    ) dut (
        .pClk(pClk),
        .pReset(pReset),
        .RxD(RxD),
        .rd_ack(rd_ack),
        .err_clr(err_clr),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_done(rx_done),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 pClk = ~pClk;

    always @(posedge pClk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rx_done pops one expected byte.
    always @(negedge pClk) begin
        if (rx_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            @(negedge pClk);
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", 32'(rx_data), 32'hFFFF_FFFF);
            end else begin
                chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge pClk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        RxD = 1'b0;
        fall_cyc = cyc;
        wait_cyc(BITC);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            wait_cyc(BITC);
        end
        RxD = stop;
        wait_cyc(BITC);
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        wait_cyc(1);
        rd_ack = 1'b0;
        wait_cyc(1);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        wait_cyc(1);
    endtask

    // Raise a one-cycle pulse on rd_ack or err_clr in the next accept cycle.
    task automatic hit_accept(input bit use_ack);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge pClk);
            if (rx_done === 1'b1) seen = 1'b1;
        end
        chk("accept_seen", 32'(seen), 32'd1);
        if (use_ack) rd_ack = 1'b1;
        else err_clr = 1'b1;
        @(posedge pClk);
        #1;
        rd_ack = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        int d0;
        int lat;

        wait_cyc(3);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_done", 32'(rx_done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        pReset = 1'b0;
        wait_cyc(5);

        // Basic frame and latency.
        d0 = done_cnt;
        exp_q.push_back(8'h14);
        send_frame(8'h14, 1'b1);
        wait_cyc(10);
        lat = done_cyc - fall_cyc;
        chk("one_done_14", 32'(done_cnt - d0), 32'd1);
        chk("latency_ok", 32'((lat >= 608) && (lat <= 612)), 32'd1);
        chk("valid_14", 32'(rx_valid), 32'd1);
        chk("ferr_14", 32'(frame_err), 32'd0);
        chk("ovr_14", 32'(overrun), 32'd0);
        chk("idle_14", 32'(busy), 32'd0);

        pulse_ack();
        chk("ack_clears_valid", 32'(rx_valid), 32'd0);
        pulse_ack();
        chk("ack_idle_noop", 32'(rx_valid), 32'd0);
        chk("ack_keeps_data", 32'(rx_data), 32'h14);

        // Short glitch is rejected at the mid-start check.
        d0 = done_cnt;
        RxD = 1'b0;
        wait_cyc(5);
        chk("glitch_busy", 32'(busy), 32'd1);
        wait_cyc(5);
        RxD = 1'b1;
        wait_cyc(60);
        chk("glitch_idle", 32'(busy), 32'd0);
        chk("glitch_no_done", 32'(done_cnt - d0), 32'd0);
        chk("glitch_valid", 32'(rx_valid), 32'd0);
        chk("glitch_ferr", 32'(frame_err), 32'd0);

        // Stop bit low, line then held low.
        d0 = done_cnt;
        send_frame(8'hA5, 1'b0);
        wait_cyc(2 * BITC);
        chk("ferr_set", 32'(frame_err), 32'd1);
        chk("ferr_wait_busy", 32'(busy), 32'd1);
        chk("ferr_valid", 32'(rx_valid), 32'd0);
        chk("ferr_no_done", 32'(done_cnt - d0), 32'd0);
        RxD = 1'b1;
        wait_cyc(20);
        chk("ferr_back_idle", 32'(busy), 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        wait_cyc(10);
        chk("after_ferr_valid", 32'(rx_valid), 32'd1);
        chk("ferr_sticky", 32'(frame_err), 32'd1);
        chk("ferr_one_done", 32'(done_cnt - d0), 32'd1);
        pulse_clr();
        chk("ferr_cleared", 32'(frame_err), 32'd0);
        pulse_ack();

        // Overrun.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1);
        wait_cyc(10);
        chk("ovr_data", 32'(rx_data), 32'h22);
        chk("ovr_set", 32'(overrun), 32'd1);
        pulse_ack();
        chk("ovr_ack_valid", 32'(rx_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        pulse_clr();
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Read coincident with the second accept: no overrun.
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1);
        exp_q.push_back(8'h44);
        fork
            send_frame(8'h44, 1'b1);
            hit_accept(1'b1);
        join
        wait_cyc(10);
        chk("ack_sync_valid", 32'(rx_valid), 32'd1);
        chk("ack_sync_ovr", 32'(overrun), 32'd0);
        chk("ack_sync_data", 32'(rx_data), 32'h44);

        // Clear coincident with an overrun event: the event wins.
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            hit_accept(1'b0);
        join
        wait_cyc(10);
        chk("clr_vs_ovr", 32'(overrun), 32'd1);

        // Reset during data bit 4 of 0xFF.
        d0 = done_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                wait_cyc(5 * BITC + 32);
                pReset = 1'b1;
                wait_cyc(1);
                chk("mid_rst_data", 32'(rx_data), 32'h00);
                chk("mid_rst_valid", 32'(rx_valid), 32'd0);
                chk("mid_rst_ovr", 32'(overrun), 32'd0);
                chk("mid_rst_ferr", 32'(frame_err), 32'd0);
                chk("mid_rst_busy", 32'(busy), 32'd0);
                pReset = 1'b0;
            end
        join
        wait_cyc(10);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_cyc(10);
        chk("post_rst_valid", 32'(rx_valid), 32'd1);
        chk("post_rst_data", 32'(rx_data), 32'h5A);
        chk("post_rst_ovr", 32'(overrun), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, pClk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate.
REQ-003 SHALL derive local constant DIV = CLK_FREQ/(BAUD*16), integer division (651 at defaults), pClk cycles per oversample tick.
REQ-004 pClk  input  1  sole clock; all logic on rising edge.
REQ-005 pReset  input  1  synchronous, active-high reset.
REQ-006 RxD  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 rd_ack  input  1  one-cycle pulse from register block when the Rx data register is read.
REQ-008 err_clr  input  1  one-cycle pulse clearing sticky error flags.
REQ-009 rx_data  output  8  last correctly framed byte.
REQ-010 rx_valid  output  1  level; unread byte held in rx_data.
REQ-011 rx_done  output  1  one-cycle pulse per accepted frame (IRQ source).
REQ-012 frame_err  output  1  sticky; stop bit sampled low.
REQ-013 overrun  output  1  sticky; frame accepted while previous byte unread.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 RxD SHALL pass a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value RxS only.
REQ-016 Tick counter SHALL count 0..DIV-1 and emit tick when count = DIV-1; it SHALL be held at 0 in IDLE and WAIT_HIGH, run otherwise.
REQ-017 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; 4-bit tick index and 3-bit bit index.
REQ-018 IDLE: RxS = 0 -> START, tick index 0.
REQ-019 START: on 8th tick (mid start bit) RxS = 0 -> DATA, tick index 0, bit index 0; RxS = 1 -> IDLE (glitch rejected, no flag, no output change).
REQ-020 DATA: on every 16th tick SHALL shift RxS into MSB of 8-bit shift register (shift right); after bit index 7 -> STOP.
REQ-021 STOP: on 16th tick, RxS = 1 -> accept frame, IDLE; RxS = 0 -> frame_err set, byte discarded, rx_data/rx_valid unchanged, WAIT_HIGH.
REQ-022 WAIT_HIGH: remain until RxS = 1, then IDLE (break/held-low line generates no repeated frames).
REQ-023 Accept SHALL, in the same cycle: rx_data <= shift register, rx_valid <= 1, rx_done = 1 for exactly that cycle.
REQ-024 Accept while rx_valid = 1 and rd_ack = 0 SHALL set overrun and overwrite rx_data with the new byte.
REQ-025 Accept coincident with rd_ack SHALL leave rx_valid = 1 with new data and SHALL NOT set overrun.
REQ-026 rd_ack without accept SHALL clear rx_valid next cycle; rd_ack with rx_valid = 0 has no effect.
REQ-027 err_clr SHALL clear frame_err and overrun; an error event in the same cycle SHALL win (flag stays 1).
REQ-028 Latency: rx_done SHALL assert between 152*DIV and 152*DIV+4 cycles after the RxD falling edge at the pin.
REQ-029 Next start bit SHALL be detectable from the cycle after accept (mid stop bit onward).

Reset
REQ-030 pReset SHALL force, on the next rising edge: state IDLE, all counters 0, shift register 0, rx_data 0x00, rx_valid 0, rx_done 0, frame_err 0, overrun 0, busy 0, synchronizer flops 1.
REQ-031 pReset mid-frame SHALL abandon the frame with no output or flag change other than REQ-030; reception resumes on the next falling edge after reset release.

Verification
REQ-032 Defaults, frame 0x14 at 104160 ns/bit, stop high -> rx_data = 0x14, rx_valid = 1, single rx_done pulse, frame_err = 0, overrun = 0.
REQ-033 RxD low 3000 ns then high -> state returns IDLE, no rx_done, rx_valid and flags unchanged.
REQ-034 Frame 0xA5 with stop bit low, line held low 2 bit times -> frame_err = 1, rx_valid = 0, exactly one error, no rx_done; next frame 0x3C accepted normally; err_clr -> frame_err = 0.
REQ-035 Frames 0x11 then 0x22 without rd_ack -> rx_data = 0x22, overrun = 1; rd_ack -> rx_valid = 0, overrun stays 1.
REQ-036 rd_ack pulsed in the rx_done cycle of the second of two back-to-back frames -> rx_valid = 1, overrun = 0.
REQ-037 pReset asserted during data bit 4 of frame 0xFF -> all outputs 0 per REQ-030; subsequent frame 0x5A received correctly.
